// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with decoded active video,
// active-low syncs, end-of-line and start-of-vertical-blanking strobes, and
// a wrapping frame counter. Default timing is 640x480@60 (800x525 total).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       next_frame,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode constants are 11 bits wide so a sync end landing exactly on
    // 1024 still compares correctly against the 10-bit counters.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_LST = 11'(V_ACTIVE - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
    endgenerate

    logic [10:0] x_w;
    logic [10:0] y_w;
    logic        x_last;
    logic        y_last;

    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign x_last = (x_w == H_LAST);
    assign y_last = (y_w == V_LAST);

    // Zero-latency decode straight from the counter registers.
    always_comb begin
        active     = (x_w < H_ACT_END) && (y_w < V_ACT_END);
        hsync      = !((x_w >= HS_BEGIN) && (x_w < HS_END));
        vsync      = !((y_w >= VS_BEGIN) && (y_w < VS_END));
        line_end   = pix_en && x_last;
        next_frame = pix_en && x_last && (y_w == V_ACT_LST);
    end

    // Raster counters and frame counter advance only on enabled pixel edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_count <= '0;
        end else if (pix_en) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? 10'd0 : y + 10'd1;
            end else begin
                x <= x + 10'd1;
            end
            if (next_frame) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance checked cycle by
// cycle through an expected-value queue, plus a default 640x480 instance
// checked over its first two lines against hand-derived numbers.
module tb_vga_timing_gen;

    // Reduced geometry: 15 x 10 total, 150 clocks per frame at full rate.
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = 15, VT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_active, s_hsync, s_vsync, s_line_end, s_next_frame;
    logic       d_active, d_hsync, d_vsync, d_line_end, d_next_frame;
    logic [7:0] s_fc, d_fc;

    int passed = 0;
    int total  = 0;

    logic [63:0] q[$];
    int          mx = 0, my = 0, mfc = 0;
    int          cyc = 0;
    int          nf_cyc[$];
    int          prev_fc = 0;
    logic        saw_wrap = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x(s_x), .y(s_y), .active(s_active), .hsync(s_hsync), .vsync(s_vsync),
        .line_end(s_line_end), .next_frame(s_next_frame), .frame_count(s_fc)
    );

    vga_timing_gen dut_dflt (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .x(d_x), .y(d_y), .active(d_active), .hsync(d_hsync), .vsync(d_vsync),
        .line_end(d_line_end), .next_frame(d_next_frame), .frame_count(d_fc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [63:0] pack(input logic [9:0] px, input logic [9:0] py,
                                         input logic a, input logic h, input logic v,
                                         input logic le, input logic nf, input logic [7:0] fc);
        return {30'd0, px, py, a, h, v, le, nf, fc};
    endfunction

    function automatic logic [63:0] exp_vec(input logic en);
        logic a, h, v, le, nf;
        a  = (mx < HA) && (my < VA);
        h  = !(mx >= 10 && mx <= 12);
        v  = !(my >= 7 && my <= 8);
        le = en && (mx == 14);
        nf = en && (mx == 14) && (my == 5);
        return pack(10'(mx), 10'(my), a, h, v, le, nf, 8'(mfc));
    endfunction

    task automatic step(input logic en);
        pix_en = en;
        q.push_back(exp_vec(en));
        @(posedge clk);
        if (en) begin
            if (mx == 14 && my == 5) mfc = (mfc + 1) % 256;
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        #1;
    endtask

    // Monitor: compares the small instance against the queued expectation.
    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            logic [63:0] e;
            e = q.pop_front();
            chk("raster", pack(s_x, s_y, s_active, s_hsync, s_vsync, s_line_end,
                               s_next_frame, s_fc), e);
        end
        if (rst_n) begin
            if (s_next_frame) nf_cyc.push_back(cyc);
            if (prev_fc == 255 && s_fc == 8'd0) saw_wrap = 1'b1;
            prev_fc = int'(s_fc);
        end
    end

    // Default 640x480 instance over its first two lines after reset release.
    initial begin : dflt_watch
        int hs_low, hs_first, le_cnt, le_x, act_low;
        hs_low = 0; hs_first = -1; le_cnt = 0; le_x = -1; act_low = -1;
        @(posedge rst_n);
        @(negedge clk);
        chk("dflt_reset", {49'd0, d_x, d_y, d_active, d_hsync, d_vsync},
            {49'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        for (int k = 0; k <= 1600; k++) begin
            if (k < 800) begin
                if (!d_hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = k;
                end
                if (d_line_end) begin
                    le_cnt++;
                    le_x = int'(d_x);
                end
                if (!d_active && act_low < 0) act_low = k;
            end
            if (k == 1)    chk("dflt_x_after_1", 64'(d_x), 64'd1);
            if (k == 640)  chk("dflt_x640_inactive", {d_x, d_active}, {10'd640, 1'b0});
            if (k == 800)  chk("dflt_line_wrap", {d_x, d_y}, {10'd0, 10'd1});
            if (k == 1600) chk("dflt_line2_wrap", {d_x, d_y}, {10'd0, 10'd2});
            @(negedge clk);
        end
        chk("dflt_hsync_width", 64'(hs_low), 64'd96);
        chk("dflt_hsync_start", 64'(hs_first), 64'd656);
        chk("dflt_line_end_count", 64'(le_cnt), 64'd1);
        chk("dflt_line_end_x", 64'(le_x), 64'd799);
        chk("dflt_active_end", 64'(act_low), 64'd640);
    end

    initial begin : stim
        int guard;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", pack(s_x, s_y, s_active, s_hsync, s_vsync, s_line_end,
                               s_next_frame, s_fc),
            pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        rst_n = 1'b1;

        // Full rate: frame period 150 clocks.
        nf_cyc.delete();
        for (int i = 0; i < 1700; i++) step(1'b1);
        chk("nf_count_full", 64'(nf_cyc.size()), 64'd11);
        if (nf_cyc.size() >= 2)
            chk("frame_period_full", 64'(nf_cyc[1] - nf_cyc[0]), 64'd150);

        // Half-rate enable: frame period doubles to 300 clocks.
        nf_cyc.delete();
        for (int i = 0; i < 700; i++) step(i % 2 == 1);
        chk("nf_seen_half", 64'(nf_cyc.size() >= 2), 64'd1);
        if (nf_cyc.size() >= 2)
            chk("frame_period_half", 64'(nf_cyc[1] - nf_cyc[0]), 64'd300);

        // Async reset mid-line at (7,4), between clock edges.
        guard = 0;
        while (!(mx == 7 && my == 4) && guard < 200) begin
            step(1'b1);
            guard++;
        end
        chk("reach_mid_line", {s_x, s_y}, {10'd7, 10'd4});
        chk("fc_before_reset", 64'(s_fc >= 8'd11), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", pack(s_x, s_y, s_active, s_hsync, s_vsync, s_line_end,
                                s_next_frame, s_fc),
            pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        mx = 0; my = 0; mfc = 0; prev_fc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 256 full frames: frame_count wraps back to 0, corner (14,9) covered.
        for (int i = 0; i < 256 * 150; i++) step(1'b1);
        chk("fc_wrap_seen", 64'(saw_wrap), 64'd1);
        chk("fc_after_256", 64'(s_fc), 64'd0);
        chk("pos_after_256", {s_x, s_y}, {10'd0, 10'd0});

        guard = 0;
        while (q.size() > 0 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
